// File: rtl/enigma_forward_stepper.sv
// ---------------------------------------------------------------------------
// enigma_forward_stepper
//   Forward half of an Enigma I datapath. For each accepted letter it steps
//   the rotor odometer, including the middle-rotor double-step. It then maps
//   the letter through rotor III (fast), rotor II (middle), rotor I (slow) and
//   reflector B. It presents the reflected letter together with the post-step
//   rotor positions, which the reverse path needs for the same character.
//
// Ports
//   clk_i                       rising-edge clock
//   rst_ni                      asynchronous active-low reset
//   load_i                      load r*_init_i into the positions (IDLE only)
//   r1_init_i/r2_init_i/r3_init_i  initial fast/middle/slow positions (0..25)
//   in_valid_i / in_ready_o     letter handshake (ready only in IDLE)
//   data_in_i                   plaintext letter, 0..25 = A..Z
//   out_valid_o / out_ready_i   result handshake
//   data_out_o                  reflector output letter
//   r1_pos_o/r2_pos_o/r3_pos_o  registered rotor positions after the step
//   err_o                       one-cycle pulse: invalid letter or init dropped
// ---------------------------------------------------------------------------
module enigma_forward_stepper #(
  parameter int ALPHA    = 26,
  parameter int R1_NOTCH = 21,
  parameter int R2_NOTCH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [4:0] r1_init_i,
  input  logic [4:0] r2_init_i,
  input  logic [4:0] r3_init_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [4:0] data_in_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [4:0] data_out_o,
  output logic [4:0] r1_pos_o,
  output logic [4:0] r2_pos_o,
  output logic [4:0] r3_pos_o,
  output logic       err_o
);

  typedef enum logic [1:0] {IDLE, STEP, FWD, OUT} state_t;

  localparam logic [4:0] LAST  = 5'(ALPHA - 1);
  localparam logic [5:0] MOD6  = 6'(ALPHA);

  // Wiring tables: entry i is the letter that contact i is wired to.
  localparam logic [4:0] W_III [26] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17,
    5'd19, 5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12,
    5'd14, 5'd20, 5'd18, 5'd16};
  localparam logic [4:0] W_II [26] = '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23,
    5'd1, 5'd11, 5'd7, 5'd22, 5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24,
    5'd5, 5'd21, 5'd14, 5'd4};
  localparam logic [4:0] W_I [26] = '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21,
    5'd25, 5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8,
    5'd1, 5'd17, 5'd2, 5'd9};
  localparam logic [4:0] REF_B [26] = '{5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3,
    5'd15, 5'd23, 5'd13, 5'd6, 5'd14, 5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2,
    5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

  // sel: 0 = rotor III, 1 = rotor II, 2 = rotor I, 3 = reflector B.
  // Indices are always 0..25 here, so the tables are never overrun.
  function automatic logic [4:0] wireLookup(input logic [1:0] sel, input logic [4:0] idx);
    logic [4:0] res;
    case (sel)
      2'd0:    res = W_III[idx];
      2'd1:    res = W_II[idx];
      2'd2:    res = W_I[idx];
      default: res = REF_B[idx];
    endcase
    return res;
  endfunction

  // y = (W[(x+p) mod 26] - p) mod 26. The sums are widened to 6 bits so that
  // neither the offset nor the +26 bias can overflow.
  function automatic logic [4:0] mapRotor(input logic [1:0] sel, input logic [4:0] x,
                                          input logic [4:0] p);
    logic [5:0] entry;
    logic [5:0] back;
    entry = {1'b0, x} + {1'b0, p};
    if (entry >= MOD6) entry = entry - MOD6;
    back = {1'b0, wireLookup(sel, entry[4:0])} + MOD6 - {1'b0, p};
    if (back >= MOD6) back = back - MOD6;
    return back[4:0];
  endfunction

  function automatic logic [4:0] incWrap(input logic [4:0] x);
    return (x == LAST) ? 5'd0 : x + 5'd1;
  endfunction

  state_t     state_q, state_d;
  logic [4:0] r1_pos_q, r1_pos_d;
  logic [4:0] r2_pos_q, r2_pos_d;
  logic [4:0] r3_pos_q, r3_pos_d;
  logic [4:0] letter_q, letter_d;
  logic [4:0] data_out_q, data_out_d;
  logic       err_q, err_d;

  logic       initsOk;
  logic       midNotch;
  logic [4:0] afterFast, afterMid, afterSlow;

  assign initsOk   = (r1_init_i <= LAST) && (r2_init_i <= LAST) && (r3_init_i <= LAST);
  // The middle rotor sits on its own notch: it steps again (double-step) and carries the slow rotor.
  assign midNotch  = (r2_pos_q == 5'(R2_NOTCH));
  assign afterFast = mapRotor(2'd0, letter_q, r1_pos_q);
  assign afterMid  = mapRotor(2'd1, afterFast, r2_pos_q);
  assign afterSlow = mapRotor(2'd2, afterMid, r3_pos_q);

  // State and datapath registers; reset clears everything and returns to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      r1_pos_q   <= '0;
      r2_pos_q   <= '0;
      r3_pos_q   <= '0;
      letter_q   <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      r1_pos_q   <= r1_pos_d;
      r2_pos_q   <= r2_pos_d;
      r3_pos_q   <= r3_pos_d;
      letter_q   <= letter_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic. In IDLE a load request takes priority over a letter, and
  // bad inputs are dropped with an error pulse. STEP advances the odometer
  // using the pre-step positions. FWD registers the reflected letter. OUT
  // holds the result until the consumer takes it.
  always_comb begin
    state_d    = state_q;
    r1_pos_d   = r1_pos_q;
    r2_pos_d   = r2_pos_q;
    r3_pos_d   = r3_pos_q;
    letter_d   = letter_q;
    data_out_d = data_out_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          if (initsOk) begin
            r1_pos_d = r1_init_i;
            r2_pos_d = r2_init_i;
            r3_pos_d = r3_init_i;
          end else begin
            err_d = 1'b1;
          end
        end else if (in_valid_i) begin
          if (data_in_i > LAST) begin
            err_d = 1'b1;
          end else begin
            letter_d = data_in_i;
            state_d  = STEP;
          end
        end
      end
      STEP: begin
        r1_pos_d = incWrap(r1_pos_q);
        if ((r1_pos_q == 5'(R1_NOTCH)) || midNotch) r2_pos_d = incWrap(r2_pos_q);
        if (midNotch) r3_pos_d = incWrap(r3_pos_q);
        state_d = FWD;
      end
      FWD: begin
        data_out_d = wireLookup(2'd3, afterSlow);
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == OUT);
  assign data_out_o  = data_out_q;
  assign r1_pos_o    = r1_pos_q;
  assign r2_pos_o    = r2_pos_q;
  assign r3_pos_o    = r3_pos_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_enigma_forward_stepper.sv
// ---------------------------------------------------------------------------
// tb_enigma_forward_stepper
//   Directed bench for enigma_forward_stepper. A behavioural Enigma model
//   pushes the expected letter and positions into a queue whenever a letter
//   is sent. Entries are popped and compared when out_valid appears.
//   Stimulus is driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_enigma_forward_stepper;

  typedef struct {
    logic [4:0] data;
    logic [4:0] p1;
    logic [4:0] p2;
    logic [4:0] p3;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       load;
  logic [4:0] r1Init, r2Init, r3Init;
  logic       inValid;
  logic       inReady;
  logic [4:0] dataIn;
  logic       outValid;
  logic       outReady;
  logic [4:0] dataOut;
  logic [4:0] r1Pos, r2Pos, r3Pos;
  logic       err;

  int   checks   = 0;
  int   failures = 0;
  exp_t expQ[$];
  int   mp1 = 0, mp2 = 0, mp3 = 0;

  string wIII = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
  string wII  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  string wI   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  string refB = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  enigma_forward_stepper dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .load_i      (load),
    .r1_init_i   (r1Init),
    .r2_init_i   (r2Init),
    .r3_init_i   (r3Init),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .data_in_i   (dataIn),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .data_out_o  (dataOut),
    .r1_pos_o    (r1Pos),
    .r2_pos_o    (r2Pos),
    .r3_pos_o    (r3Pos),
    .err_o       (err)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is ever bypassed.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int mapThrough(string w, int x, int p);
    int idx;
    int c;
    idx = (x + p) % 26;
    c   = int'(w[idx]) - 65;
    return (c - p + 26) % 26;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkPositions(input string tag, input int e1, input int e2, input int e3);
    checkValue({tag, "_r1"}, 32'(r1Pos), 32'(e1));
    checkValue({tag, "_r2"}, 32'(r2Pos), 32'(e2));
    checkValue({tag, "_r3"}, 32'(r3Pos), 32'(e3));
  endtask

  // Send one letter. Valid letters advance the model odometer and push the
  // expected result.
  task automatic applyStimulus(input logic [4:0] letter);
    int   waited;
    bit   step2;
    bit   step3;
    int   x;
    exp_t e;
    waited = 0;
    while (!inReady && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkValue("in_ready_before_send", 32'(inReady), 32'd1);
    inValid = 1'b1;
    dataIn  = letter;
    @(negedge clk);
    inValid = 1'b0;
    if (letter <= 5'd25) begin
      step2 = (mp1 == 21) || (mp2 == 4);
      step3 = (mp2 == 4);
      mp1 = (mp1 + 1) % 26;
      if (step2) mp2 = (mp2 + 1) % 26;
      if (step3) mp3 = (mp3 + 1) % 26;
      x = mapThrough(wIII, int'(letter), mp1);
      x = mapThrough(wII, x, mp2);
      x = mapThrough(wI, x, mp3);
      x = mapThrough(refB, x, 0);
      e.data = 5'(x);
      e.p1   = 5'(mp1);
      e.p2   = 5'(mp2);
      e.p3   = 5'(mp3);
      expQ.push_back(e);
    end
  endtask

  // Wait (bounded) for out_valid, pop the scoreboard and compare. lat counts
  // falling edges from the return of applyStimulus until out_valid is seen.
  task automatic checkOutput(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (!outValid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkValue({tag, "_out_valid"}, 32'(outValid), 32'd1);
    checkValue({tag, "_queue_nonempty"}, 32'(expQ.size() > 0), 32'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (outValid) begin
        checkValue({tag, "_data_out"}, 32'(dataOut), 32'(e.data));
        checkPositions(tag, int'(e.p1), int'(e.p2), int'(e.p3));
      end
    end
    if (outReady && outValid) begin
      @(negedge clk);
      checkValue({tag, "_out_valid_drop"}, 32'(outValid), 32'd0);
    end
  endtask

  task automatic loadPositions(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                               input bit withLetter);
    load    = 1'b1;
    r1Init  = a;
    r2Init  = b;
    r3Init  = c;
    inValid = withLetter;
    dataIn  = 5'd2;
    @(negedge clk);
    load    = 1'b0;
    inValid = 1'b0;
    if (a <= 5'd25 && b <= 5'd25 && c <= 5'd25) begin
      mp1 = int'(a);
      mp2 = int'(b);
      mp3 = int'(c);
      checkValue("load_err_low", 32'(err), 32'd0);
    end else begin
      checkValue("load_bad_err", 32'(err), 32'd1);
    end
    checkPositions("load", mp1, mp2, mp3);
    checkValue("load_in_ready", 32'(inReady), 32'd1);
  endtask

  initial begin
    int   lat;
    int   waited;
    exp_t held;
    rstN     = 1'b0;
    load     = 1'b0;
    r1Init   = '0;
    r2Init   = '0;
    r3Init   = '0;
    inValid  = 1'b0;
    dataIn   = '0;
    outReady = 1'b1;

    // T1a: values while held in reset.
    @(negedge clk);
    @(negedge clk);
    checkValue("rst_out_valid", 32'(outValid), 32'd0);
    checkValue("rst_err", 32'(err), 32'd0);
    checkValue("rst_data_out", 32'(dataOut), 32'd0);
    checkPositions("rst", 0, 0, 0);
    rstN = 1'b1;
    @(negedge clk);
    checkValue("rst_in_ready", 32'(inReady), 32'd1);

    // T2: A at (0,0,0) -> (1,0,0), S; latency of two clock edges past the accept edge.
    applyStimulus(5'd0);
    checkOutput("t2", lat);
    checkValue("t2_latency", 32'(lat), 32'd2);

    // T3: double-step across the middle notch.
    loadPositions(5'd21, 5'd3, 5'd0, 1'b0);
    applyStimulus(5'd0);
    checkOutput("t3a", lat);
    applyStimulus(5'd1);
    checkOutput("t3b", lat);

    // T4: fast rotor wraps 25 -> 0 with no carry.
    loadPositions(5'd25, 5'd10, 5'd25, 1'b0);
    applyStimulus(5'd7);
    checkOutput("t4", lat);

    // T5: backpressure; the result holds and in_valid is ignored during OUT.
    outReady = 1'b0;
    applyStimulus(5'd4);
    waited = 0;
    while (!outValid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    held = (expQ.size() > 0) ? expQ[0] : '{5'd0, 5'd0, 5'd0, 5'd0};
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      dataIn  = 5'd9;
      @(negedge clk);
      checkValue("t5_hold_valid", 32'(outValid), 32'd1);
      checkValue("t5_in_ready", 32'(inReady), 32'd0);
      checkValue("t5_hold_data", 32'(dataOut), 32'(held.data));
      checkPositions("t5_hold", int'(held.p1), int'(held.p2), int'(held.p3));
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    checkOutput("t5", lat);
    @(negedge clk);
    @(negedge clk);
    checkValue("t5_no_extra_output", 32'(outValid), 32'd0);
    checkPositions("t5_after", mp1, mp2, mp3);

    // T6: invalid letter and invalid init are dropped with an error pulse.
    applyStimulus(5'd27);
    checkValue("t6_err_pulse", 32'(err), 32'd1);
    @(negedge clk);
    checkValue("t6_err_clear", 32'(err), 32'd0);
    checkValue("t6_no_output", 32'(outValid), 32'd0);
    checkValue("t6_in_ready", 32'(inReady), 32'd1);
    checkPositions("t6_letter", mp1, mp2, mp3);
    loadPositions(5'd30, 5'd1, 5'd1, 1'b0);
    @(negedge clk);
    checkValue("t6_load_err_clear", 32'(err), 32'd0);

    // A load coinciding with in_valid wins; no letter is accepted.
    loadPositions(5'd3, 5'd4, 5'd5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkValue("load_wins_no_output", 32'(outValid), 32'd0);
    checkPositions("load_wins", 3, 4, 5);

    // A short run of random letters checked against the model.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(5'($urandom_range(0, 25)));
      checkOutput("rand", lat);
    end

    // T1b: reset while in OUT discards the letter and zeroes the positions.
    outReady = 1'b0;
    applyStimulus(5'd11);
    waited = 0;
    while (!outValid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkValue("t1_reached_out", 32'(outValid), 32'd1);
    rstN = 1'b0;
    #1;
    checkValue("t1_out_valid", 32'(outValid), 32'd0);
    checkPositions("t1", 0, 0, 0);
    if (expQ.size() > 0) void'(expQ.pop_front());
    mp1 = 0;
    mp2 = 0;
    mp3 = 0;
    @(negedge clk);
    rstN     = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    checkValue("t1_in_ready", 32'(inReady), 32'd1);
    applyStimulus(5'd0);
    checkOutput("t1_after", lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
